silly_function: RTL and testbench

//   Small 3-input Boolean function block: y = ~b & ~c | a & ~b, i.e. y=1 only for {a,b,c} = 000, 100, 101.
//   y is purely combinational; a registered copy and a saturating hit counter give a clocked, resettable view.

---
 rtl/silly_function_pkg.sv | 13 +
 rtl/silly_function_if.sv | 14 +
 rtl/silly_function_lut.sv | 14 +
 rtl/silly_function.sv | 52 +++++
 tb/tb_silly_function.sv | 138 +++++++++++++
 5 files changed

// File: rtl/silly_function_pkg.sv
// Shared types and defaults for the silly_function 3-input Boolean block.
package silly_function_pkg;

  // bit i is y for index i = {a,b,c}; ones at indices 0, 4 and 5
  localparam logic [7:0] SILLY_TT = 8'h31;

  typedef logic [2:0] sf_idx_t;

  function automatic sf_idx_t sf_pack(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/silly_function_if.sv
// Signal bundle for one silly_function instance: function inputs plus its three views of y.
interface silly_function_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             c;
  logic             y;
  logic             y_q;
  logic [CNT_W-1:0] hit_cnt;

  modport master (output a, b, c, input y, y_q, hit_cnt);
  modport slave  (input a, b, c, output y, y_q, hit_cnt);
endinterface

// File: rtl/silly_function_lut.sv
// Pure combinational truth-table lookup: y = TRUTH_TABLE[idx], zero latency.
module silly_function_lut
  import silly_function_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = SILLY_TT
) (
  input  sf_idx_t idx,
  output logic    y
);

  // A single continuous select lets an X/Z index show up as X on y.
  assign y = TRUTH_TABLE[idx];

endmodule

// File: rtl/silly_function.sv
// 3-input Boolean function with a combinational output, a registered copy and a saturating hit counter.
module silly_function
  import silly_function_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = SILLY_TT,
  parameter int         CNT_W       = 8
) (
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  input  logic             clk,
  input  logic             rst,
  output logic             y_q,
  output logic [CNT_W-1:0] hit_cnt
);

  logic             y_reg_d;
  logic             y_reg_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // y depends only on a/b/c so positional 4-port use works without a clock.
  silly_function_lut #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut (
    .idx(sf_pack(a, b, c)),
    .y  (y)
  );

  always_comb begin
    y_reg_d = y;
    cnt_d   = cnt_q;
    if (y && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_reg_q <= y_reg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_q     = y_reg_q;
  assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_silly_function.sv
// Bench for silly_function: default table, 2-bit counter and alternate table instances driven in lockstep.
module tb_silly_function;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  silly_function_if #(.CNT_W(8)) if0 ();
  silly_function_if #(.CNT_W(2)) if1 ();
  silly_function_if #(.CNT_W(8)) if2 ();

  silly_function #(.TRUTH_TABLE(8'h31), .CNT_W(8)) dut0 (
    .a(if0.a), .b(if0.b), .c(if0.c), .y(if0.y),
    .clk(clk), .rst(rst), .y_q(if0.y_q), .hit_cnt(if0.hit_cnt)
  );
  silly_function #(.TRUTH_TABLE(8'h31), .CNT_W(2)) dut1 (
    .a(if1.a), .b(if1.b), .c(if1.c), .y(if1.y),
    .clk(clk), .rst(rst), .y_q(if1.y_q), .hit_cnt(if1.hit_cnt)
  );
  silly_function #(.TRUTH_TABLE(8'h80), .CNT_W(8)) dut2 (
    .a(if2.a), .b(if2.b), .c(if2.c), .y(if2.y),
    .clk(clk), .rst(rst), .y_q(if2.y_q), .hit_cnt(if2.hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: y from the spec's truth table, counter as a clamped integer.
  logic [7:0] tt      [3] = '{8'h31, 8'h31, 8'h80};
  int         cnt_max [3] = '{255, 3, 255};
  int         exp_cnt [3] = '{0, 0, 0};
  logic       exp_yq  [3] = '{1'b0, 1'b0, 1'b0};
  int         cur_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_abc(input int idx);
    logic [2:0] v;
    v = 3'(idx);
    cur_idx = idx;
    {if0.a, if0.b, if0.c} = v;
    {if1.a, if1.b, if1.c} = v;
    {if2.a, if2.b, if2.c} = v;
  endtask

  task automatic check_y(input string tag);
    chk({tag, "/y0"}, {31'b0, if0.y}, {31'b0, tt[0][cur_idx]});
    chk({tag, "/y1"}, {31'b0, if1.y}, {31'b0, tt[1][cur_idx]});
    chk({tag, "/y2"}, {31'b0, if2.y}, {31'b0, tt[2][cur_idx]});
  endtask

  task automatic step(input string tag, input logic r);
    rst = r;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        exp_yq[i]  = 1'b0;
        exp_cnt[i] = 0;
      end else begin
        exp_yq[i] = tt[i][cur_idx];
        if (tt[i][cur_idx] == 1'b1) exp_cnt[i] = (exp_cnt[i] < cnt_max[i]) ? exp_cnt[i] + 1 : exp_cnt[i];
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "/yq0"},  {31'b0, if0.y_q}, {31'b0, exp_yq[0]});
    chk({tag, "/yq1"},  {31'b0, if1.y_q}, {31'b0, exp_yq[1]});
    chk({tag, "/yq2"},  {31'b0, if2.y_q}, {31'b0, exp_yq[2]});
    chk({tag, "/cnt0"}, {24'b0, if0.hit_cnt}, 32'(exp_cnt[0]));
    chk({tag, "/cnt1"}, {30'b0, if1.hit_cnt}, 32'(exp_cnt[1]));
    chk({tag, "/cnt2"}, {24'b0, if2.hit_cnt}, 32'(exp_cnt[2]));
    check_y(tag);
  endtask

  logic [3:0] sat_seq [6];

  initial begin
    rst = 1'b1;
    set_abc(0);

    // Exhaustive combinational sweep (also covers the 8'h80 table).
    for (int i = 0; i < 8; i++) begin
      set_abc(i);
      #10;
      check_y("comb");
    end

    // Reset held for two edges with abc=000.
    set_abc(0);
    step("rst_a", 1'b1);
    step("rst_b", 1'b1);

    // Pipeline: 100 then 010.
    set_abc(4);
    step("pipe_100", 1'b0);
    set_abc(2);
    step("pipe_010", 1'b0);
    chk("pipe_cnt_once", {24'b0, if0.hit_cnt}, 32'd1);

    // Saturation of the 2-bit counter with abc=101.
    step("sat_rst", 1'b1);
    set_abc(5);
    for (int i = 0; i < 6; i++) begin
      step("sat", 1'b0);
      sat_seq[i] = {2'b0, if1.hit_cnt};
    end
    chk("sat_seq", {8'b0, sat_seq[0], sat_seq[1], sat_seq[2], sat_seq[3], sat_seq[4], sat_seq[5]},
        32'h0012_3333);

    // Reset mid-count, then resume.
    set_abc(0);
    step("mid_rst", 1'b1);
    step("mid_resume", 1'b0);
    chk("mid_resume_cnt", {30'b0, if1.hit_cnt}, 32'd1);

    // Randomized inputs with occasional reset.
    for (int i = 0; i < 300; i++) begin
      set_abc(int'($urandom_range(7)));
      step("rand", ($urandom_range(15) == 0));
    end

    // Drive the 8-bit counter into saturation.
    step("sat8_rst", 1'b1);
    set_abc(0);
    for (int i = 0; i < 262; i++) step("sat8", 1'b0);
    chk("sat8_final", {24'b0, if0.hit_cnt}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
